// File: rtl/mux_stream_pkg.sv
// Shared definitions for the single-wire mux stream link (serializer and deserializer).
`timescale 1ns/1ps
package mux_stream_pkg;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_order_e;

  // Lane-index width; a 1-lane link still needs a 1-bit select.
  function automatic int sel_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mux_stream_hold.sv
// One-deep output holding register with valid/ready handshake and sticky overflow.
`timescale 1ns/1ps
module mux_stream_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vld  <= 1'b0;
      ovf  <= 1'b0;
    end else if (push) begin
      // A pop on the same edge frees the slot, so the new word is not a drop.
      if (!vld || rdy) begin
        dout <= din;
        vld  <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (vld && rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_stream_deser.sv
// Re-assembles one-bit-per-strobe serial lanes into WIDTH-bit words on a valid/ready port.
`timescale 1ns/1ps
module mux_stream_deser
  import mux_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            CE,
  input  logic                            I,
  input  logic                            SOF,
  output logic [sel_width(WIDTH)-1:0]     SEL,
  output logic [WIDTH-1:0]                O,
  output logic                            O_VLD,
  input  logic                            O_RDY,
  output logic                            OVF
);

  localparam int          SW    = sel_width(WIDTH);
  localparam lane_order_e ORDER = (MSB_FIRST != 0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;
  localparam logic [SW-1:0] LAST_LANE = SW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [SW-1:0]    sel_q;
  logic [SW-1:0]    sel_next;
  logic [SW-1:0]    lane;
  logic [SW-1:0]    pos;
  logic             last;
  logic             complete;

  assign last     = (sel_q == LAST_LANE);
  assign complete = CE && !SOF && last;

  // SOF restarts from a clean word, discarding any partial one.
  always_comb begin
    word_next = SOF ? '0 : shreg;
    lane      = SOF ? '0 : sel_q;
    pos       = (ORDER == LANE_MSB_FIRST) ? (LAST_LANE - lane) : lane;
    word_next[pos] = I;
    if (SOF)
      sel_next = SW'(1);
    else if (last)
      sel_next = '0;
    else
      sel_next = sel_q + SW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg <= '0;
      sel_q <= '0;
    end else if (CE) begin
      shreg <= word_next;
      sel_q <= sel_next;
    end
  end

  assign SEL = sel_q;

  mux_stream_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk  (CLK),
    .rst_n(RST_N),
    .push (complete),
    .din  (word_next),
    .rdy  (O_RDY),
    .dout (O),
    .vld  (O_VLD),
    .ovf  (OVF)
  );

endmodule
